// File: rtl/sync_tx_if.sv
// rtl/sync_tx_if.sv - word-in / serial-out bus of the sync_tx framer
// master drives the payload handshake, slave is the framer.
interface sync_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic              sout;
   logic              sout_valid;
   logic              busy;
   logic              done;

   modport master (
      output din, din_valid,
      input  din_ready, sout, sout_valid, busy, done
   );

   modport slave (
      input  din, din_valid,
      output din_ready, sout, sout_valid, busy, done
   );
endinterface

// File: rtl/sync_tx.sv
// rtl/sync_tx.sv - serial framer: 1011 sync marker, MSB-first payload, idle gap
// Define SYNC_TX_PARITY_EN to append an even-parity bit after the payload.
module sync_tx #(
   parameter int DATA_W    = 8,
   parameter int IDLE_BITS = 2
) (
   input  logic       clk,
   input  logic       rst,
   sync_tx_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SYNC = 3'd1,
      DATA = 3'd2,
      PAR  = 3'd3,
      GAP  = 3'd4
   } state_t;

   localparam logic [3:0] SYNC_PAT = 4'b1011;
   localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);
   localparam logic [3:0] LAST_GAP = 4'(IDLE_BITS - 1);
`ifdef SYNC_TX_PARITY_EN
   localparam bit PAR_ON = 1'b1;
`else
   localparam bit PAR_ON = 1'b0;
`endif

   state_t            state;
   logic [1:0]        sidx;
   logic [4:0]        dcnt;
   logic [3:0]        gcnt;
   logic [DATA_W-1:0] shreg;
   logic              sout_r;
   logic              valid_r;
   logic              done_r;
`ifdef SYNC_TX_PARITY_EN
   logic              par_r;
`endif

   logic [1:0] sidx_nx;
   assign sidx_nx = sidx + 2'd1;

   assign bus.din_ready  = (state == IDLE) && !rst;
   assign bus.sout       = sout_r;
   assign bus.sout_valid = valid_r;
   assign bus.done       = done_r;
   assign bus.busy       = (state != IDLE);

   // Outputs are registered alongside the state that owns them, so the
   // bit on sout always belongs to the state currently held.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sidx    <= '0;
         dcnt    <= '0;
         gcnt    <= '0;
         shreg   <= '0;
         sout_r  <= 1'b0;
         valid_r <= 1'b0;
         done_r  <= 1'b0;
`ifdef SYNC_TX_PARITY_EN
         par_r   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               sout_r  <= 1'b0;
               valid_r <= 1'b0;
               done_r  <= 1'b0;
               if (bus.din_valid) begin
                  state   <= SYNC;
                  shreg   <= bus.din;
                  sidx    <= '0;
                  sout_r  <= SYNC_PAT[3];
                  valid_r <= 1'b1;
`ifdef SYNC_TX_PARITY_EN
                  par_r   <= ^bus.din;
`endif
               end
            end
            SYNC: begin
               if (sidx != 2'd3) begin
                  sidx   <= sidx_nx;
                  sout_r <= SYNC_PAT[2'd3 - sidx_nx];
               end else begin
                  state  <= DATA;
                  dcnt   <= '0;
                  sout_r <= shreg[DATA_W-1];
                  shreg  <= shreg << 1;
                  done_r <= (LAST_BIT == 5'd0) && !PAR_ON;
               end
            end
            DATA: begin
               if (dcnt != LAST_BIT) begin
                  dcnt   <= dcnt + 5'd1;
                  sout_r <= shreg[DATA_W-1];
                  shreg  <= shreg << 1;
                  done_r <= (dcnt == LAST_BIT - 5'd1) && !PAR_ON;
               end else begin
`ifdef SYNC_TX_PARITY_EN
                  state   <= PAR;
                  sout_r  <= par_r;
                  done_r  <= 1'b1;
`else
                  state   <= GAP;
                  gcnt    <= '0;
                  sout_r  <= 1'b0;
                  valid_r <= 1'b0;
                  done_r  <= 1'b0;
`endif
               end
            end
`ifdef SYNC_TX_PARITY_EN
            PAR: begin
               state   <= GAP;
               gcnt    <= '0;
               sout_r  <= 1'b0;
               valid_r <= 1'b0;
               done_r  <= 1'b0;
            end
`endif
            GAP: begin
               sout_r  <= 1'b0;
               valid_r <= 1'b0;
               done_r  <= 1'b0;
               if (gcnt == LAST_GAP) begin
                  state <= IDLE;
               end else begin
                  gcnt <= gcnt + 4'd1;
               end
            end
            default: begin
               state   <= IDLE;
               sout_r  <= 1'b0;
               valid_r <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule
